mult_err_monitor: RTL
=====================

MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 17, sample-counter width; 17 covers the exhaustive 65536-pair 8x8 sweep.
REQ-002 The block SHALL have parameter SUM_W, default 32, error-sum width.
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port start  in  1  one-cycle pulse that begins a measurement run.
REQ-006 Port cfg_num  in  CNT_W  samples per run, sampled on start.
REQ-007 Port in_valid  in  1  operand/product triple valid.
REQ-008 Port in_ready  out  1  block accepts the triple this cycle.
REQ-009 Port op_a, op_b  in  8 each  multiplier operands.
REQ-010 Port prod_apx  in  16  approximate product from the 8x8 approximate multiplier under test.
REQ-011 Port busy  out  1  high in RUN or DRAIN.
REQ-012 Port done  out  1  one-cycle pulse when results are final.
REQ-013 Ports err_cnt (CNT_W), sum_ed (SUM_W), max_ed (16), smp_cnt (CNT_W)  out  run statistics: number of erroneous samples, sum of error distances, maximum error distance, samples accepted.

Function
REQ-014 A transfer SHALL occur on a cycle where in_valid and in_ready are both high; no other cycle SHALL count as a sample.
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE->RUN on start with cfg_num != 0; IDLE->DONE on start with cfg_num == 0.
REQ-017 On start the block SHALL latch cfg_num and clear err_cnt, sum_ed, max_ed, smp_cnt and the pipeline valids in the same cycle.
REQ-018 in_ready SHALL be high only in RUN while smp_cnt < latched cfg_num; it SHALL be combinational on state and counter only, never on in_valid.
REQ-019 RUN->DRAIN on the cycle the cfg_num-th transfer occurs.
REQ-020 DRAIN->DONE when both pipeline stages are empty; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Start SHALL be ignored in RUN, DRAIN and DONE.
REQ-022 Pipeline stage 1 SHALL register the accepted triple and form exact = op_a*op_b (16-bit unsigned).
REQ-023 Stage 2 SHALL register ed = |exact - prod_apx| as a 16-bit unsigned value, computed from a 17-bit signed difference.
REQ-024 Accumulation SHALL follow stage 2, so a sample affects the statistics 3 cycles after its transfer: err_cnt += (ed != 0), sum_ed += ed, max_ed = max(max_ed, ed).
REQ-025 smp_cnt SHALL increment in the transfer cycle itself.
REQ-026 sum_ed SHALL NOT wrap: the maximum is 65535*65536 < 2^32; with SUM_W < 32 it SHALL saturate at all-ones.
REQ-027 Statistics outputs SHALL hold their values after DONE until the next accepted start.

Reset
REQ-028 Assertion of rst_n low SHALL, at any time including mid-run, immediately force: state IDLE, in_ready 0, busy 0, done 0, all statistics 0, pipeline valids 0, latched cfg_num 0.
REQ-029 After reset release, no done pulse SHALL occur without a new start.

Structure
REQ-030 A shared package mult_err_pkg SHALL hold the FSM state enum, the CNT_W/SUM_W defaults and the 8/16-bit operand/product width constants.
REQ-031 One sub-module ed_unit SHALL compute the exact product and the absolute error distance (combinational, registered by the parent).

Verification
REQ-032 Exact DUT: cfg_num=4, prod_apx=op_a*op_b for (3,5),(255,255),(0,7),(16,16) -> err_cnt=0, sum_ed=0, max_ed=0, smp_cnt=4, done one cycle after the pipeline drains.
REQ-033 Error mix: cfg_num=3, triples (2,3,7),(10,10,90),(255,255,0) -> err_cnt=3, sum_ed=1+10+65025=65036, max_ed=65025.
REQ-034 Backpressure: cfg_num=2 with in_valid held high for 5 cycles -> exactly 2 transfers; in_ready low from the 3rd cycle; smp_cnt=2.
REQ-035 Zero length and re-start: start with cfg_num=0 -> done on the next cycle, stats 0; a start pulse during RUN -> no clear and no restart.
REQ-036 Reset mid-run: rst_n low after 2 of 4 transfers -> all outputs 0 asynchronously; IDLE; no done after release.
REQ-037 Exhaustive sweep: cfg_num=65536, all (a,b) pairs with a behavioural approximate model -> err_cnt, sum_ed and max_ed match the model, with no overflow.

Source files
------------

// File: rtl/mult_err_pkg.sv
// Shared definitions for the multiplier error monitor: FSM states,
// default counter widths and the operand/product widths of the 8x8 multiplier.
package mult_err_pkg;

  localparam int CNT_W_DEF = 17;
  localparam int SUM_W_DEF = 32;
  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mult_err_monitor_if.sv
// Sample stream carrying operand/product triples from the multiplier under
// test into the monitor; the monitor is the slave and drives in_ready back.
interface mult_err_monitor_if;
  import mult_err_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [PROD_W-1:0] prod_apx;

  modport master (
    output in_valid, op_a, op_b, prod_apx,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_a, op_b, prod_apx,
    output in_ready
  );

endinterface

// File: rtl/mult_err_monitor_ed_unit.sv
// Combinational arithmetic for the monitor: the exact 8x8 product of the
// incoming operands, and the absolute error distance between a registered
// exact product and the registered approximate product.
module ed_unit
  import mult_err_pkg::*;
(
  input  logic [OP_W-1:0]   op_a_i,
  input  logic [OP_W-1:0]   op_b_i,
  output logic [PROD_W-1:0] exact_o,
  input  logic [PROD_W-1:0] exact_i,
  input  logic [PROD_W-1:0] apx_i,
  output logic [PROD_W-1:0] ed_o
);

  logic signed [PROD_W:0] diff;
  logic signed [PROD_W:0] negDiff;

  assign exact_o = PROD_W'(op_a_i) * PROD_W'(op_b_i);

  // One extra bit keeps the difference of two unsigned 16-bit values exact,
  // so the magnitude always fits back into 16 bits.
  assign diff    = $signed({1'b0, exact_i}) - $signed({1'b0, apx_i});
  assign negDiff = -diff;
  assign ed_o    = diff[PROD_W] ? negDiff[PROD_W-1:0] : diff[PROD_W-1:0];

endmodule

// File: rtl/mult_err_monitor.sv
// Error-statistics monitor for an approximate 8x8 multiplier. A run accepts
// cfg_num triples, pushes each through a two-stage pipeline (exact product,
// then error distance) and accumulates count, sum and maximum of the errors.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_num,
  mult_err_monitor_if.slave  in_if,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   sum_ed,
  output logic [PROD_W-1:0]  max_ed,
  output logic [CNT_W-1:0]   smp_cnt
);

  localparam int SUM_EXT_W = (SUM_W > PROD_W) ? SUM_W + 1 : PROD_W + 1;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  cfgNum_q;
  logic [CNT_W-1:0]  smpCnt_q;
  logic [CNT_W-1:0]  errCnt_q;
  logic [CNT_W-1:0]  errCnt_d;
  logic [SUM_W-1:0]  sumEd_q;
  logic [SUM_W-1:0]  sumEd_d;
  logic [PROD_W-1:0] maxEd_q;
  logic [PROD_W-1:0] maxEd_d;

  logic              s1Valid_q;
  logic [PROD_W-1:0] s1Exact_q;
  logic [PROD_W-1:0] s1Apx_q;
  logic              s2Valid_q;
  logic [PROD_W-1:0] s2Ed_q;

  logic              inReady;
  logic              xfer;
  logic              startAcc;
  logic              lastXfer;
  logic              drained;
  logic [PROD_W-1:0] exactNow;
  logic [PROD_W-1:0] edNow;
  logic [SUM_EXT_W-1:0] sumExt;

  ed_unit u_ed (
    .op_a_i  (in_if.op_a),
    .op_b_i  (in_if.op_b),
    .exact_o (exactNow),
    .exact_i (s1Exact_q),
    .apx_i   (s1Apx_q),
    .ed_o    (edNow)
  );

  // Ready depends only on state and progress so a source may wait on it.
  assign inReady        = (state_q == RUN) && (smpCnt_q < cfgNum_q);
  assign in_if.in_ready = inReady;
  assign xfer           = in_if.in_valid && inReady;
  assign startAcc       = start && (state_q == IDLE);
  assign lastXfer       = xfer && ((smpCnt_q + CNT_W'(1)) == cfgNum_q);
  assign drained        = !s1Valid_q && !s2Valid_q;

  // Run control: accept a start in IDLE, stop accepting after the last
  // sample, wait for the pipeline to empty, then pulse done for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cfgNum_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cfgNum_q <= cfg_num;
            if (cfg_num == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (lastXfer) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two pipeline stages: exact product with its approximate partner, then
  // the error distance between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Exact_q <= '0;
      s1Apx_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Ed_q    <= '0;
    end else if (startAcc) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
    end else begin
      s1Valid_q <= xfer;
      if (xfer) begin
        s1Exact_q <= exactNow;
        s1Apx_q   <= in_if.prod_apx;
      end
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Ed_q <= edNow;
      end
    end
  end

  // Next values of the error statistics for the sample leaving stage 2;
  // the sum clamps at all-ones instead of wrapping on narrow builds.
  always_comb begin
    errCnt_d = errCnt_q;
    if (s2Ed_q != '0) begin
      errCnt_d = errCnt_q + CNT_W'(1);
    end
    sumExt  = SUM_EXT_W'(sumEd_q) + SUM_EXT_W'(s2Ed_q);
    sumEd_d = sumExt[SUM_W-1:0];
    if (|sumExt[SUM_EXT_W-1:SUM_W]) begin
      sumEd_d = '1;
    end
    maxEd_d = (s2Ed_q > maxEd_q) ? s2Ed_q : maxEd_q;
  end

  // Statistics registers: cleared by an accepted start, sample count bumps
  // on the transfer itself, error figures on stage-2 output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpCnt_q <= '0;
      errCnt_q <= '0;
      sumEd_q  <= '0;
      maxEd_q  <= '0;
    end else if (startAcc) begin
      smpCnt_q <= '0;
      errCnt_q <= '0;
      sumEd_q  <= '0;
      maxEd_q  <= '0;
    end else begin
      if (xfer) begin
        smpCnt_q <= smpCnt_q + CNT_W'(1);
      end
      if (s2Valid_q) begin
        errCnt_q <= errCnt_d;
        sumEd_q  <= sumEd_d;
        maxEd_q  <= maxEd_d;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = errCnt_q;
  assign sum_ed  = sumEd_q;
  assign max_ed  = maxEd_q;
  assign smp_cnt = smpCnt_q;

endmodule
